// File: rtl/apb_pkg.sv
// Shared APB completer types, default widths and address-decode helpers.
// Optional wait states are enabled by defining APB_WAIT_EN.
package apb_pkg;

  localparam int APB_ADDR_W      = 32;
  localparam int APB_DATA_W      = 32;
  localparam int APB_DEPTH       = 64;
  localparam int APB_WAIT_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  // Word index of a byte address; lsb is log2 of the bytes per word.
  function automatic logic [63:0] apb_word_idx(input logic [63:0] addr, input int lsb);
    return addr >> lsb;
  endfunction

  // Misaligned or beyond the last word of the bank.
  function automatic logic apb_addr_err(input logic [63:0] addr, input int lsb, input int depth);
    logic [63:0] mask;
    logic [63:0] limit;
    mask  = (64'd1 << lsb) - 64'd1;
    limit = 64'(depth) << lsb;
    return ((addr & mask) != 64'd0) || (addr >= limit);
  endfunction

endpackage

// File: rtl/apb_regbank.sv
// DEPTH x DATA_W register bank: synchronous write port, registered read port
// with a clear, contents cleared by the asynchronous reset.
module apb_regbank #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_widx,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [IDX_W-1:0]  i_ridx,
  input  logic              i_clr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_widx] <= i_wdata;
    end
  end

  // Clear wins so the read bus returns to zero once a transfer ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_rdata <= '0;
    else if (i_clr) r_rdata <= '0;
    else if (i_re)  r_rdata <= r_mem[i_ridx];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/apb_completer.sv
// APB completer serving a local register bank, all outputs registered.
// Define APB_WAIT_EN to insert WAIT_CYCLES wait states per transfer.
module apb_completer
  import apb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int DEPTH       = APB_DEPTH,
  parameter int WAIT_CYCLES = APB_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output apb_state_t        o_dbg_state
);

  localparam int LSB   = $clog2(DATA_W / 8);
  localparam int IDX_W = $clog2(DEPTH);
`ifdef APB_WAIT_EN
  localparam int LOAD  = WAIT_CYCLES;
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
`else
  localparam int LOAD  = WAIT_CYCLES * 0;
`endif

  // Handshake: the setup edge is the one where psel=1 and penable=0 while idle
  // (or just after a completion); the transfer completes on the edge where
  // psel & penable & pready, and pready/pslverr fall on that same edge.
  apb_state_t        r_state;
  logic              r_done;
  logic              r_write;
  logic              r_err;
  logic              r_pready;
  logic              r_pslverr;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_wdata;

  logic [IDX_W-1:0]  w_idx;
  logic              w_err;
  logic              w_setup;
  logic              w_active;
  logic              w_complete;
  logic              w_abort;
  logic              w_raise;
  logic              w_tick;
  logic              w_re;
  logic              w_we;
  logic [IDX_W-1:0]  w_ridx;
  logic [DATA_W-1:0] w_rdata;

  assign w_idx = IDX_W'(apb_word_idx(64'(paddr), LSB));
  assign w_err = apb_addr_err(64'(paddr), LSB, DEPTH);

  assign w_active   = (r_state == ACCESS) && !r_done;
  assign w_setup    = psel && !penable && ((r_state == IDLE) || ((r_state == ACCESS) && r_done));
  assign w_complete = w_active && psel && penable && r_pready;
  assign w_abort    = w_active && !psel;

`ifdef APB_WAIT_EN
  logic [CNT_W-1:0] r_cnt;

  assign w_tick = w_active && psel && penable && (r_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_cnt <= '0;
    else if (w_setup) r_cnt <= CNT_W'(WAIT_CYCLES);
    else if (w_abort) r_cnt <= '0;
    else if (w_tick)  r_cnt <= r_cnt - CNT_W'(1);
  end

  assign w_raise = (w_setup && (LOAD == 0)) || (w_tick && (r_cnt == CNT_W'(1)));
`else
  assign w_tick  = 1'b0;
  assign w_raise = w_setup;
`endif

  // Read data is fetched on the edge that raises pready, from the live
  // address when that edge is also the setup edge.
  assign w_re   = w_raise && (w_setup ? (!pwrite && !w_err) : (!r_write && !r_err));
  assign w_ridx = w_setup ? w_idx : r_idx;
  assign w_we   = w_complete && r_write && !r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_done    <= 1'b0;
      r_write   <= 1'b0;
      r_err     <= 1'b0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_idx     <= '0;
      r_wdata   <= '0;
    end else if (w_setup) begin
      r_state   <= ACCESS;
      r_done    <= 1'b0;
      r_write   <= pwrite;
      r_err     <= w_err;
      r_idx     <= w_idx;
      r_wdata   <= pwdata;
      r_pready  <= (LOAD == 0);
      r_pslverr <= (LOAD == 0) && w_err;
    end else if (w_abort) begin
      r_state   <= IDLE;
      r_done    <= 1'b0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
    end else if (w_complete) begin
      r_done    <= 1'b1;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
    end else if ((r_state == ACCESS) && r_done) begin
      r_state   <= IDLE;
      r_done    <= 1'b0;
    end else if (w_raise) begin
      r_pready  <= 1'b1;
      r_pslverr <= r_err;
    end
  end

  apb_regbank #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_regbank (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_widx  (r_idx),
    .i_wdata (r_wdata),
    .i_re    (w_re),
    .i_ridx  (w_ridx),
    .i_clr   (w_complete || w_abort),
    .o_rdata (w_rdata)
  );

  assign prdata      = w_rdata;
  assign pready      = r_pready;
  assign pslverr     = r_pslverr;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_apb_completer.sv
// Directed bench for apb_completer; wait-state expectations follow APB_WAIT_EN.
module tb_apb_completer;
  import apb_pkg::*;

`ifdef APB_WAIT_EN
  localparam int EXP_W = 2;
`else
  localparam int EXP_W = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  apb_state_t  dbg_state;

  int n_cmp;
  int n_bad;

  apb_completer #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .DEPTH       (64),
    .WAIT_CYCLES (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    psel = 1'b0; penable = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // One full transfer; starts and returns 1 time unit after a rising edge.
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err, output int waits);
    bit got;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    waits = 0; got = 1'b0; rd = '0; err = 1'b0;
    for (int n = 0; n < 32 && !got; n++) begin
      if (pready) begin
        rd = prdata; err = pslverr; got = 1'b1;
      end else begin
        waits++;
      end
      @(posedge clk); #1;
    end
    if (!got) check("xfer_timeout", 32'd0, 32'd1);
    psel = 1'b0; penable = 1'b0;
  endtask

  logic [31:0] rd;
  logic        err;
  int          waits;
  bit          seen;

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pready", 32'(pready), 32'd0);
    check("rst_pslverr", 32'(pslverr), 32'd0);
    check("rst_prdata", prdata, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    idle_cycles(2);

    // penable without a setup phase is ignored
    penable = 1'b1; psel = 1'b0;
    @(posedge clk); #1;
    check("stray_penable_state", 32'(dbg_state), 32'(IDLE));
    idle_cycles(1);

    // 1: zero-latency-style write then read
    apb_xfer(1'b1, 32'h10, 32'hDEAD_BEEF, rd, err, waits);
    check("t1_wr_err", 32'(err), 32'd0);
    check("t1_wr_waits", 32'(waits), 32'(EXP_W));
    apb_xfer(1'b0, 32'h10, 32'h0, rd, err, waits);
    check("t1_rd_data", rd, 32'hDEAD_BEEF);
    check("t1_rd_err", 32'(err), 32'd0);
    check("t1_rd_waits", 32'(waits), 32'(EXP_W));
    check("t1_prdata_cleared", prdata, 32'd0);
    check("t1_pready_dropped", 32'(pready), 32'd0);
    idle_cycles(2);
    check("t1_back_to_idle", 32'(dbg_state), 32'(IDLE));

    // 2: read of an untouched word, latency check
    apb_xfer(1'b0, 32'h4, 32'h0, rd, err, waits);
    check("t2_rd_data", rd, 32'd0);
    check("t2_rd_waits", 32'(waits), 32'(EXP_W));
    idle_cycles(1);

    // 3: out-of-range and misaligned writes
    apb_xfer(1'b1, 32'h100, 32'h1234_5678, rd, err, waits);
    check("t3_oor_err", 32'(err), 32'd1);
    check("t3_oor_waits", 32'(waits), 32'(EXP_W));
    apb_xfer(1'b1, 32'h13, 32'hCAFE_F00D, rd, err, waits);
    check("t3_mis_err", 32'(err), 32'd1);
    check("t3_mis_waits", 32'(waits), 32'(EXP_W));
    apb_xfer(1'b0, 32'h0, 32'h0, rd, err, waits);
    check("t3_rd0_data", rd, 32'd0);
    check("t3_rd0_err", 32'(err), 32'd0);
    apb_xfer(1'b0, 32'h10, 32'h0, rd, err, waits);
    check("t3_rd10_data", rd, 32'hDEAD_BEEF);
    apb_xfer(1'b0, 32'h100, 32'h0, rd, err, waits);
    check("t3_oor_rd_data", rd, 32'd0);
    check("t3_oor_rd_err", 32'(err), 32'd1);
    idle_cycles(1);

    // 4: back-to-back writes, no idle between them
    apb_xfer(1'b1, 32'h8, 32'h1, rd, err, waits);
    check("t4_post_complete_state", 32'(dbg_state), 32'(ACCESS));
    apb_xfer(1'b1, 32'hC, 32'h2, rd, err, waits);
    check("t4_wr2_err", 32'(err), 32'd0);
    apb_xfer(1'b0, 32'h8, 32'h0, rd, err, waits);
    check("t4_rd8", rd, 32'h1);
    apb_xfer(1'b0, 32'hC, 32'h0, rd, err, waits);
    check("t4_rdC", rd, 32'h2);
    idle_cycles(1);

    // 5: psel dropped during the access phase of a write
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'h55;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    check("t5_abort_state", 32'(dbg_state), 32'(IDLE));
    check("t5_abort_pready", 32'(pready), 32'd0);
    idle_cycles(1);
    apb_xfer(1'b0, 32'h20, 32'h0, rd, err, waits);
    check("t5_rd20", rd, 32'd0);
    idle_cycles(1);

    // 6: reset asserted while pready is high on a read
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h10;
    @(posedge clk); #1;
    penable = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 16 && !seen; n++) begin
      if (pready) seen = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("t6_pready_seen", 32'(seen), 32'd1);
    check("t6_prdata_before", prdata, 32'hDEAD_BEEF);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_pready", 32'(pready), 32'd0);
    check("t6_rst_pslverr", 32'(pslverr), 32'd0);
    check("t6_rst_prdata", prdata, 32'd0);
    check("t6_rst_state", 32'(dbg_state), 32'(IDLE));
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_cycles(1);
    apb_xfer(1'b0, 32'h10, 32'h0, rd, err, waits);
    check("t6_rd10_after_rst", rd, 32'd0);
    apb_xfer(1'b0, 32'h8, 32'h0, rd, err, waits);
    check("t6_rd8_after_rst", rd, 32'd0);
    idle_cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
